// File: rtl/bat_program_loader.sv
// Byte-stream program loader for the bat_amateur core: holds the core in HALT,
// writes a length-prefixed 16-bit word image into RAM, then pulses CPU reset and releases HALT.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | after reset, core halted, waiting for start
//   S_LEN_HI  | waiting for word count high byte (no timeout here)
//   S_LEN_LO  | waiting for word count low byte, range check on accept
//   S_DAT_HI  | waiting for data word high byte
//   S_DAT_LO  | waiting for data word low byte
//   S_WRITE   | RAM write strobe held for WRITE_CYCLES cycles
//   S_RELEASE | CPU reset asserted for RST_CYCLES cycles
//   S_DONE    | core running, loader idle
//   S_ERROR   | bad length or byte timeout, core halted
module bat_program_loader #(
   parameter logic [15:0] BASE_ADDR    = 16'h0000,
   parameter logic [15:0] MAX_WORDS    = 16'd256,
   parameter int unsigned WRITE_CYCLES = 2,
   parameter int unsigned RST_CYCLES   = 4,
   parameter int unsigned TIMEOUT      = 65535,
   parameter logic        WRITE_LEVEL  = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        halt,
   output logic        cpu_rst,
   output logic [15:0] address,
   output logic [15:0] data_out,
   output logic        data_oe,
   output logic        ext_ram_rw,
   output logic        ext_ram_en,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] word_count
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DAT_HI,
      S_DAT_LO,
      S_WRITE,
      S_RELEASE,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [31:0] WR_LOAD  = WRITE_CYCLES - 1;
   localparam logic [31:0] RS_LOAD  = RST_CYCLES - 1;
   localparam logic [31:0] TMO_LOAD = TIMEOUT;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  len_hi;
   logic [15:0] n_len;
   logic [31:0] tmr;
   logic [31:0] tmo_cnt;
   logic        accept;
   logic        counting;
   logic        tmo_hit;
   logic        can_start;
   logic [15:0] len_full;
   logic [15:0] count_inc;

   // All outputs decode the state register, so async reset forces them at once
   assign byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                       (state == S_DAT_HI) || (state == S_DAT_LO);
   assign halt       = (state != S_DONE);
   assign cpu_rst    = (state == S_RELEASE);
   assign ext_ram_en = (state == S_WRITE);
   assign data_oe    = (state == S_WRITE);
   assign ext_ram_rw = (state == S_WRITE) ? WRITE_LEVEL : ~WRITE_LEVEL;
   assign busy       = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
   assign done       = (state == S_DONE);
   assign err        = (state == S_ERROR);

   assign accept    = byte_valid && byte_ready;
   assign counting  = (state == S_LEN_LO) || (state == S_DAT_HI) || (state == S_DAT_LO);
   assign tmo_hit   = counting && !accept && (tmo_cnt == 32'd1);
   assign can_start = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
   assign len_full  = {len_hi, byte_in};
   assign count_inc = word_count + 16'd1;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) state_nxt = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (accept) state_nxt = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (accept) begin
               if (len_full > MAX_WORDS)  state_nxt = S_ERROR;
               else if (len_full == 16'd0) state_nxt = S_RELEASE;
               else                        state_nxt = S_DAT_HI;
            end else if (tmo_hit) begin
               state_nxt = S_ERROR;
            end
         end
         S_DAT_HI: begin
            if (accept)       state_nxt = S_DAT_LO;
            else if (tmo_hit) state_nxt = S_ERROR;
         end
         S_DAT_LO: begin
            if (accept)       state_nxt = S_WRITE;
            else if (tmo_hit) state_nxt = S_ERROR;
         end
         S_WRITE: begin
            if (tmr == 32'd0) state_nxt = (count_inc == n_len) ? S_RELEASE : S_DAT_HI;
         end
         S_RELEASE: begin
            if (tmr == 32'd0) state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         len_hi     <= 8'd0;
         n_len      <= 16'd0;
         data_out   <= 16'd0;
         address    <= BASE_ADDR;
         word_count <= 16'd0;
         tmr        <= 32'd0;
         tmo_cnt    <= TMO_LOAD;
      end else begin
         state <= state_nxt;

         if (can_start && start) begin
            word_count <= 16'd0;
            address    <= BASE_ADDR;
         end

         if (accept) begin
            case (state)
               S_LEN_HI: len_hi         <= byte_in;
               S_LEN_LO: n_len          <= len_full;
               S_DAT_HI: data_out[15:8] <= byte_in;
               S_DAT_LO: data_out[7:0]  <= byte_in;
               default: ;
            endcase
         end

         if ((state == S_WRITE) && (tmr == 32'd0)) begin
            word_count <= count_inc;
            address    <= address + 16'd1;
         end

         // Shared phase timer: loaded on entry to a timed state, counts down to terminal zero
         if (state_nxt != state) begin
            case (state_nxt)
               S_WRITE:   tmr <= WR_LOAD;
               S_RELEASE: tmr <= RS_LOAD;
               default:   tmr <= 32'd0;
            endcase
         end else if (tmr != 32'd0) begin
            tmr <= tmr - 32'd1;
         end

         if (!counting || accept)     tmo_cnt <= TMO_LOAD;
         else if (tmo_cnt != 32'd0)   tmo_cnt <= tmo_cnt - 32'd1;
      end
   end

endmodule
